// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared defaults, capture FSM states and RGB565 to RGB444 conversion
// Contents: H_ACTIVE_DEF / V_ACTIVE_DEF frame-size defaults, cap_state_t, rgb565_to_444()
package cam_pkg;

   localparam int H_ACTIVE_DEF = 640;
   localparam int V_ACTIVE_DEF = 480;

   typedef enum logic [1:0] {
      WAIT_VS_HI,
      WAIT_VS_LO,
      ACTIVE
   } cap_state_t;

   // OV7670 sends RGB565 high byte first: b1 = RRRRRGGG, b2 = GGGBBBBB.
   // Keep the top 4 bits of each channel.
   function automatic logic [11:0] rgb565_to_444(input logic [7:0] b1, input logic [7:0] b2);
      return {b1[7:4], b1[2:0], b2[7], b2[4:1]};
   endfunction

endpackage

// File: rtl/cam_byte_pair.sv
// rtl/cam_byte_pair.sv - pairs camera bytes into RGB444 pixels
// Ports: clk, reset (async, active-high), clr (drop any half pixel), take (byte on d is valid),
//        d (registered camera byte), pix_valid (second byte of a pair taken this cycle),
//        pix (converted pixel, valid with pix_valid), phase (1 = first byte held)
module cam_byte_pair
   import cam_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clr,
   input  logic        take,
   input  logic [7:0]  d,
   output logic        pix_valid,
   output logic [11:0] pix,
   output logic        phase
);

   logic [7:0] b1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase <= 1'b0;
         b1    <= '0;
      end else if (clr) begin
         phase <= 1'b0;
      end else if (take) begin
         if (!phase) begin
            b1 <= d;
         end
         phase <= ~phase;
      end
   end

   // Combinational so the pixel can be registered at the top on the same edge.
   assign pix_valid = take & phase;
   assign pix       = rgb565_to_444(b1, d);

endmodule

// File: rtl/simple_counter.sv
// rtl/simple_counter.sv - saturating up-counter with synchronous clear
// Ports: clk, reset (async, active-high), clr (sync clear), inc (count enable),
//        count (current value, holds at MAX)
module simple_counter #(
   parameter int W   = 8,
   parameter int MAX = 255
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] CNT_MAX = W'(MAX);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && count != CNT_MAX) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/ov7670_capture.sv
// rtl/ov7670_capture.sv - OV7670 VSYNC/HREF framing, pixel capture and frame-buffer writes
// Ports: clk (PCLK), reset (async, active-high), vsync, href, d (camera pins), en (capture enable),
//        we/addr/wdata (frame-buffer write, RGB444), frame_done/frame_err (end-of-frame pulses),
//        busy (capturing a frame)
module ov7670_capture
   import cam_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int ADDR_W   = 19
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              vsync,
   input  logic              href,
   input  logic [7:0]        d,
   input  logic              en,
   output logic              we,
   output logic [ADDR_W-1:0] addr,
   output logic [11:0]       wdata,
   output logic              frame_done,
   output logic              frame_err,
   output logic              busy
);

   localparam int XW = $clog2(H_ACTIVE + 1);
   localparam int YW = $clog2(V_ACTIVE + 1);
   localparam logic [XW-1:0] H_MAX = XW'(H_ACTIVE);
   localparam logic [YW-1:0] V_MAX = YW'(V_ACTIVE);

   logic       vs_r, hr_r, vs_p, hr_p;
   logic [7:0] d_r;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vs_r <= 1'b0;
         hr_r <= 1'b0;
         vs_p <= 1'b0;
         hr_p <= 1'b0;
         d_r  <= '0;
      end else begin
         vs_r <= vsync;
         hr_r <= href;
         vs_p <= vs_r;
         hr_p <= hr_r;
         d_r  <= d;
      end
   end

   logic vs_rise, vs_fall, hr_fall;
   assign vs_rise = vs_r & ~vs_p;
   assign vs_fall = ~vs_r & vs_p;
   assign hr_fall = hr_p & ~hr_r;

   cap_state_t state, state_nx;
   logic       enter_active, frame_end;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= WAIT_VS_HI;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      enter_active = 1'b0;
      frame_end    = 1'b0;
      case (state)
         WAIT_VS_HI: begin
            if (vs_r) state_nx = WAIT_VS_LO;
         end
         WAIT_VS_LO: begin
            if (vs_fall) begin
               if (en) begin
                  state_nx     = ACTIVE;
                  enter_active = 1'b1;
               end else begin
                  state_nx = WAIT_VS_HI;
               end
            end
         end
         ACTIVE: begin
            if (vs_rise) begin
               state_nx  = WAIT_VS_LO;
               frame_end = 1'b1;
            end
         end
         default: state_nx = WAIT_VS_HI;
      endcase
   end

   logic active, line_end, take;
   assign active   = (state == ACTIVE);
   assign line_end = active & hr_fall;
   // Frame end takes priority over a byte arriving on the same cycle.
   assign take     = active & hr_r & ~vs_rise;

   logic        pix_valid, phase;
   logic [11:0] pix;

   cam_byte_pair u_pair (
      .clk       (clk),
      .reset     (reset),
      .clr       (enter_active | line_end | frame_end),
      .take      (take),
      .d         (d_r),
      .pix_valid (pix_valid),
      .pix       (pix),
      .phase     (phase)
   );

   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic          y_inc;

   assign y_inc = line_end & (y < V_MAX);

   simple_counter #(.W(XW), .MAX(H_ACTIVE)) u_x (
      .clk   (clk),
      .reset (reset),
      .clr   (enter_active | line_end),
      .inc   (pix_valid),
      .count (x)
   );

   simple_counter #(.W(YW), .MAX(V_ACTIVE)) u_y (
      .clk   (clk),
      .reset (reset),
      .clr   (enter_active),
      .inc   (y_inc),
      .count (y)
   );

   logic              in_range, wr, err, err_nx, clean;
   logic [YW-1:0]     y_after;
   logic [ADDR_W-1:0] line_base;

   assign in_range = (x < H_MAX) && (y < V_MAX);
   assign wr       = pix_valid & in_range;
   // Line accounting on this cycle is folded in before judging a frame end on the same cycle.
   assign err_nx   = err | (pix_valid & ~in_range) | (line_end & ((x != H_MAX) | phase));
   assign y_after  = y + YW'(y_inc);
   assign clean    = (y_after == V_MAX) & ~err_nx;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err        <= 1'b0;
         line_base  <= '0;
         we         <= 1'b0;
         addr       <= '0;
         wdata      <= '0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         if (enter_active) begin
            err       <= 1'b0;
            line_base <= '0;
         end else begin
            err <= err_nx;
            if (y_inc) line_base <= line_base + ADDR_W'(H_ACTIVE);
         end
         we <= wr;
         if (wr) begin
            addr  <= line_base + ADDR_W'(x);
            wdata <= pix;
         end
         frame_done <= frame_end & clean;
         frame_err  <= frame_end & ~clean;
         busy       <= (state_nx == ACTIVE);
      end
   end

endmodule
